// File: rtl/pipe_ctrl_pkg.sv
// Scoreboard entry type, forwarding constants and configuration legality helpers
// shared by the pipeline hazard controller and its forwarding comparators.
package pipe_ctrl_pkg;

  localparam int REG_AW_MAX = 8;
  localparam int FWD_REG    = 0;

  typedef logic [REG_AW_MAX-1:0] reg_num_t;

  typedef struct packed {
    logic     valid;
    reg_num_t rd;
    reg_num_t rs;
    reg_num_t rt;
    logic     regwrite;
    logic     memread;
  } sb_entry_t;

  function automatic bit depth_ok(int depth);
    return (depth >= 3) && (depth <= 8);
  endfunction

  function automatic bit br_stage_ok(int br_stage, int depth);
    return (br_stage >= 1) && (br_stage <= depth - 1);
  endfunction

  // r0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic sb_hit(sb_entry_t e, reg_num_t src, logic used);
    return used & e.valid & e.regwrite & (e.rd == src) & (e.rd != '0);
  endfunction

endpackage

// File: rtl/pipe_fwd_match.sv
// Forwarding select for one EX operand: lowest producing stage >= 2 wins, 0 = register file.
// Purely combinational, zero latency; never selects a load sitting in stage 2.
module pipe_fwd_match
  import pipe_ctrl_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  sb_entry_t [DEPTH:1] sb,
  input  reg_num_t            src,
  output logic [SEL_W-1:0]    sel
);

  logic unused_sb;
  assign unused_sb = ^sb;

  // Walk from the oldest stage down so the youngest producer overrides.
  always_comb begin
    sel = SEL_W'(FWD_REG);
    for (int k = DEPTH; k >= 2; k--) begin
      if (sb_hit(sb[k], src, 1'b1) && !((k == 2) && sb[k].memread)) begin
        sel = SEL_W'(k - 1);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: EX..WB scoreboard driving zero-latency stall/flush/bubble and EX
// forwarding selects plus saturating event counters; PIPE_FWD_EN enables forwarding.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int BR_STAGE = 2,
  parameter int CNT_W    = 16,
  localparam int SEL_W   = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_rs_used_i,
  input  logic              id_rt_used_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              redirect_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic [SEL_W-1:0]  fwd_a_o,
  output logic [SEL_W-1:0]  fwd_b_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  if (!depth_ok(DEPTH) || !br_stage_ok(BR_STAGE, DEPTH) || (REG_AW > REG_AW_MAX)) begin : g_cfg_err
    $error("pipe_hazard_ctrl: illegal DEPTH, BR_STAGE or REG_AW");
  end

  sb_entry_t [DEPTH:1] sb_q;
  sb_entry_t [DEPTH:1] sb_d;
  sb_entry_t           id_ent;
  reg_num_t            rs_x;
  reg_num_t            rt_x;
  logic                raw_stall;
  logic                stall;
  logic                redir;
  logic [CNT_W-1:0]    stall_cnt_q;
  logic [CNT_W-1:0]    flush_cnt_q;

  assign rs_x = REG_AW_MAX'(id_rs_i);
  assign rt_x = REG_AW_MAX'(id_rt_i);

  always_comb begin
    id_ent          = '0;
    id_ent.valid    = 1'b1;
    id_ent.rd       = REG_AW_MAX'(id_rd_i);
    id_ent.rs       = rs_x;
    id_ent.rt       = rt_x;
    id_ent.regwrite = id_regwrite_i;
    id_ent.memread  = id_memread_i;
  end

  always_comb begin
    raw_stall = 1'b0;
`ifdef PIPE_FWD_EN
    // Only a load one stage ahead and a WB producer (no RF write-through) defeat forwarding.
    raw_stall = (sb_q[1].memread &
                 (sb_hit(sb_q[1], rs_x, id_rs_used_i) | sb_hit(sb_q[1], rt_x, id_rt_used_i)))
              | sb_hit(sb_q[DEPTH], rs_x, id_rs_used_i)
              | sb_hit(sb_q[DEPTH], rt_x, id_rt_used_i);
`else
    for (int k = 1; k <= DEPTH; k++) begin
      raw_stall = raw_stall | sb_hit(sb_q[k], rs_x, id_rs_used_i)
                            | sb_hit(sb_q[k], rt_x, id_rt_used_i);
    end
`endif
  end

  // Gating with rst_n releases a pending stall or flush the moment reset asserts.
  assign redir = rst_n & redirect_i;
  assign stall = rst_n & id_valid_i & raw_stall & ~redirect_i;

  assign pc_write_o    = ~stall;
  assign ifid_write_o  = ~stall;
  assign ifid_flush_o  = redir;
  assign idex_bubble_o = stall | redir;

  always_comb begin
    sb_d    = sb_q;
    sb_d[1] = (idex_bubble_o || !id_valid_i) ? '0 : id_ent;
    for (int k = 2; k <= DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
    end
    for (int k = 1; k < BR_STAGE; k++) begin
      if (redir) sb_d[k] = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      sb_q <= sb_d;
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redir && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

`ifdef PIPE_FWD_EN
  pipe_fwd_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_fwd_a (
    .sb  (sb_q),
    .src (sb_q[1].rs),
    .sel (fwd_a_o)
  );

  pipe_fwd_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_fwd_b (
    .sb  (sb_q),
    .src (sb_q[1].rt),
    .sel (fwd_b_o)
  );
`else
  logic unused_sb;
  assign unused_sb = ^sb_q;

  assign fwd_a_o = SEL_W'(FWD_REG);
  assign fwd_b_o = SEL_W'(FWD_REG);
`endif

endmodule
